rs_codeword_serializer: RTL
===========================

# rs_codeword_serializer

Downstream stage of the RS(31,29) parallel encoder in the lpGBT-FE datapath. It captures one complete codeword per handshake: 29 message symbols plus the 2 parity symbols the encoder produces combinationally from them. It then emits the codeword one 5-bit symbol per accepted output beat, toward the line-side scrambler/gearbox. A one-deep pending buffer lets the next codeword be accepted while the current one drains, so back-to-back frames leave no bubble.

## Interface
- N, 31, codeword length in symbols
- K, 29, message length in symbols
- SYMB_BITWIDTH, 5, bits per symbol
- P (derived), N-K = 2, parity symbols
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_msg  input  SYMB_BITWIDTH*K  message; symbol i = in_msg[5i +: 5]
- in_parity  input  SYMB_BITWIDTH*P  encoder parity; symbol k = in_parity[5k +: 5]
- in_valid  input  1  in_msg/in_parity hold a codeword
- in_ready  output  1  block can capture a codeword this cycle
- out_sym  output  SYMB_BITWIDTH  current codeword symbol
- out_valid  output  1  out_sym valid
- out_ready  input  1  downstream consumes out_sym this cycle
- out_sof  output  1  out_sym is codeword symbol 0
- out_eof  output  1  out_sym is codeword symbol N-1

## Operation
- Storage: active register A (N symbols), pending register B (N symbols), pend_full flag, symbol index idx (0..N-1, 5 bits), FSM state.
- Codeword symbol order on the wire: msg symbols 0..K-1, then parity symbol 0, then parity symbol 1. Index j maps to A symbol j.
- Input accept: in_valid && in_ready. in_ready = !pend_full && !rst.
- FSM IDLE: out_valid=0. On accept, load A, idx<=0, go to SEND.
- FSM SEND: out_valid=1, out_sym=A[idx], out_sof=(idx==0), out_eof=(idx==N-1).
  - On beat (out_valid && out_ready) with idx<N-1: idx<=idx+1.
  - On beat with idx==N-1:
    - If pend_full: A<=B, pend_full<=0, idx<=0, stay in SEND.
    - Else if accept in the same cycle: A<=input, idx<=0, stay in SEND.
    - Else: go to IDLE.
  - Accept in SEND, other than the last-beat case above: B<=input, pend_full<=1.
- Simultaneous last beat and pend_full: B moves to A. in_ready is 0 that cycle, so no input is lost. in_ready returns to 1 the next cycle.
- Stall: while out_valid && !out_ready, out_sym, out_sof, out_eof and idx hold.
- Outputs are driven from registers through the idx mux only. There is no combinational path from in_* or out_ready to out_*.
- idx never exceeds N-1. Wrap from N-1 to 0 occurs only on a beat as described above.

## Timing
- Reset values: out_valid=0, out_sof=0, out_eof=0, out_sym=0, in_ready=0 while rst=1, pend_full=0, idx=0, state=IDLE.
- First cycle after rst deasserts: in_ready=1.
- Latency: accept in IDLE at cycle t gives symbol 0 with out_valid=1 at t+1.
- Throughput: with out_ready held at 1, one codeword per N=31 cycles. No gap between eof and the next sof when the next codeword is available.
- Reset mid-frame: the in-flight codeword and the pending codeword are discarded. The next clock edge puts all outputs at their reset values.

## Structure
- Shared package rs_pkg holds:
  - localparams N, K, SYMB_BITWIDTH, P.
  - The widths INP_BW, POL_BW, CW_BW = SYMB_BITWIDTH*N.
  - The FSM state enum {IDLE, SEND}.
  - A codeword_t packed type.
- Packing {in_parity, in_msg} into codeword_t is done in this block.
- No sub-module. A 5-bit counter and the 2-state FSM sit inline.
- The encoder is instantiated only in the bench.

## Test plan
- Reset then single frame: in_msg symbols i=i+1 (1..29), parity from the bench's encoder, out_ready=1.
  - Required: out_sym sequence 1..29, then parity0, then parity1.
  - out_sof only on beat 0, out_eof only on beat 30.
  - out_valid falls the cycle after eof.
- Back-to-back: frame X (all symbols 0x0A) and frame Y (all 0x15) offered continuously.
  - Required: Y sof immediately follows X eof.
  - Y is captured into B during X.
  - in_ready=0 from Y's accept until X's eof beat.
- Backpressure: out_ready=0 for 3 cycles at idx=7.
  - Required: out_sym holds symbol 7 for 4 cycles, then resumes at 8.
  - 31 beats total, no duplicate or dropped symbols.
- Simultaneous: offer a new frame exactly in the cycle of the eof beat with pend_full=0.
  - Required: the new frame's sof appears in the next cycle.
  - B is untouched.
- Pending full plus third frame: offer 3 frames while out_ready=0.
  - Required: first in A, second in B.
  - Third is held off with in_ready=0, then accepted after the first codeword's eof.
  - Output order: first, second, third.
- Reset mid-operation: assert rst at idx=12 with pend_full=1.
  - Required: next cycle out_valid=0, in_ready=0.
  - After release, in_ready=1 and the stale frames are never emitted.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared constants and types for the RS(31,29) codeword path.
package rs_pkg;
  localparam int unsigned N             = 31;
  localparam int unsigned K             = 29;
  localparam int unsigned SYMB_BITWIDTH = 5;
  localparam int unsigned P             = N - K;
  localparam int unsigned INP_BW        = SYMB_BITWIDTH * K;
  localparam int unsigned POL_BW        = SYMB_BITWIDTH * P;
  localparam int unsigned CW_BW         = SYMB_BITWIDTH * N;
  localparam int unsigned IDX_BW        = 5;

  typedef enum logic {IDLE, SEND} state_t;

  typedef logic [CW_BW-1:0] codeword_t;

  function automatic logic [SYMB_BITWIDTH-1:0] cw_symbol(input codeword_t cw,
                                                         input logic [IDX_BW-1:0] idx);
    return cw[SYMB_BITWIDTH*int'(idx) +: SYMB_BITWIDTH];
  endfunction
endpackage

// File: rtl/rs_codeword_serializer.sv
// Captures a 31-symbol RS codeword per handshake and emits it one symbol per beat,
// with a one-deep pending buffer so consecutive codewords stream without a gap.
module rs_codeword_serializer
  import rs_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INP_BW-1:0]        in_msg,
  input  logic [POL_BW-1:0]        in_parity,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [SYMB_BITWIDTH-1:0] out_sym,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_sof,
  output logic                     out_eof
);
  localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(N - 1);

  state_t            state_q, state_d;
  codeword_t         a_q, a_d;
  codeword_t         b_q, b_d;
  logic              pend_full_q, pend_full_d;
  logic [IDX_BW-1:0] idx_q, idx_d;

  codeword_t in_cw;
  logic      accept;
  logic      beat;
  logic      last;

  assign in_cw  = {in_parity, in_msg};
  assign accept = in_valid && in_ready;
  assign beat   = out_valid && out_ready;
  assign last   = (idx_q == LAST_IDX);

  always_comb begin
    in_ready  = !pend_full_q && !rst;
    out_valid = (state_q == SEND);
    out_sym   = out_valid ? cw_symbol(a_q, idx_q) : '0;
    out_sof   = out_valid && (idx_q == '0);
    out_eof   = out_valid && last;
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    pend_full_d = pend_full_q;
    idx_d       = idx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = in_cw;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (beat && !last) begin
          idx_d = idx_q + 1'b1;
        end
        // A capture coinciding with the final beat goes straight to A; any other capture parks in B.
        if (beat && last) begin
          idx_d = '0;
          if (pend_full_q) begin
            a_d         = b_q;
            pend_full_d = 1'b0;
          end else if (accept) begin
            a_d = in_cw;
          end else begin
            state_d = IDLE;
          end
        end else if (accept) begin
          b_d         = in_cw;
          pend_full_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      pend_full_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      pend_full_q <= pend_full_d;
      idx_q       <= idx_d;
    end
  end
endmodule
